// File: rtl/if_stage_pkg.sv
// Shared CPU constants and the IF/ID payload type used by the fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEFAULT = 4096;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
        logic            valid;
        logic            exc;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr: NOP_INSTR,
        pc:    '0,
        pc8:   '0,
        valid: 1'b0,
        exc:   1'b0
    };

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter: sequential increment, decode redirect, frozen while stalled.
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // A stalled redirect is dropped; decode presents it again once released.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, ROM address, legality check and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] im_addr,
    input  logic [XLEN-1:0] im_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc8_d,
    output logic            valid_d,
    output logic            exc_d
);

    // One extra bit keeps the upper bound exact when the ROM ends at 2^32.
    localparam logic [XLEN:0] IM_FIRST = {1'b0, RESET_PC};
    localparam logic [XLEN:0] IM_LAST  = IM_FIRST + (33'(IM_WORDS) * 33'd4) - 33'd4;

    logic [XLEN-1:0] pc;
    logic            fetch_legal_c;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    if_stage_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc            (pc)
    );

    assign im_addr = pc;

    assign fetch_legal_c = (pc[1:0] == 2'b00)
                        && ({1'b0, pc} >= IM_FIRST)
                        && ({1'b0, pc} <= IM_LAST);

    // Flush wins over stall; delay-slot instructions are never squashed by a redirect.
    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (!stall) begin
            if_id_d.pc    = pc;
            if_id_d.pc8   = pc + XLEN'(8);
            if_id_d.valid = 1'b1;
            if (fetch_legal_c) begin
                if_id_d.instr = im_rdata;
                if_id_d.exc   = 1'b0;
            end else begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.exc   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign instr_d = if_id_q.instr;
    assign pc_d    = if_id_q.pc;
    assign pc8_d   = if_id_q.pc8;
    assign valid_d = if_id_q.valid;
    assign exc_d   = if_id_q.exc;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference model predicts PC and IF/ID each cycle.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] R_PC   = 32'h0000_3000;
    localparam int unsigned IM_W   = 4096;
    localparam logic [31:0] IM_END = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc8;
        logic        valid;
        logic        exc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        exc_d;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc8;
    logic        m_valid;
    logic        m_exc;

    if_stage #(
        .RESET_PC(R_PC),
        .IM_WORDS(IM_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .im_addr       (im_addr),
        .im_rdata      (im_rdata),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc8_d         (pc8_d),
        .valid_d       (valid_d),
        .exc_d         (exc_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign im_rdata = rom_word(im_addr);

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= R_PC) && (a <= IM_END);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = R_PC;
        m_instr = 32'h0;
        m_pcd   = 32'h0;
        m_pc8   = 32'h0;
        m_valid = 1'b0;
        m_exc   = 1'b0;
    endtask

    task automatic check_now(input string tag);
        chk({tag, ".im_addr"}, im_addr, m_pc);
        chk({tag, ".instr"}, instr_d, m_instr);
        chk({tag, ".pc"}, pc_d, m_pcd);
        chk({tag, ".pc8"}, pc8_d, m_pc8);
        chk({tag, ".valid"}, 32'(valid_d), 32'(m_valid));
        chk({tag, ".exc"}, 32'(exc_d), 32'(m_exc));
    endtask

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic step(input string tag, input logic s, input logic f,
                        input logic rv, input logic [31:0] rpc);
        exp_t e;
        exp_t g;
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.instr = m_instr;
        e.pcd   = m_pcd;
        e.pc8   = m_pc8;
        e.valid = m_valid;
        e.exc   = m_exc;
        if (f) begin
            e.instr = 32'h0; e.pcd = 32'h0; e.pc8 = 32'h0; e.valid = 1'b0; e.exc = 1'b0;
        end else if (!s) begin
            e.pcd   = m_pc;
            e.pc8   = m_pc + 32'd8;
            e.valid = 1'b1;
            e.exc   = !legal(m_pc);
            e.instr = legal(m_pc) ? rom_word(m_pc) : 32'h0;
        end
        e.pc = s ? m_pc : (rv ? rpc : m_pc + 32'd4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        m_pc = g.pc; m_instr = g.instr; m_pcd = g.pcd; m_pc8 = g.pc8;
        m_valid = g.valid; m_exc = g.exc;
        check_now(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        #12;
        check_now("reset");
        chk("bubble_const", {instr_d, pc_d}, {IF_ID_BUBBLE.instr, IF_ID_BUBBLE.pc});
        @(negedge clk);
        reset = 1'b1;

        step("seq0", 1'b0, 1'b0, 1'b0, 32'h0);
        step("seq1", 1'b0, 1'b0, 1'b0, 32'h0);
        step("br", 1'b0, 1'b0, 1'b1, 32'h0000_3100);
        step("dslot", 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) step("stall_rd", 1'b1, 1'b0, 1'b1, 32'h0000_3200);
        step("stall_rel", 1'b0, 1'b0, 1'b1, 32'h0000_3200);

        step("to3010", 1'b0, 1'b0, 1'b1, 32'h0000_3010);
        step("stl_fl", 1'b1, 1'b1, 1'b0, 32'h0);
        step("after_fl", 1'b0, 1'b0, 1'b0, 32'h0);

        step("mis", 1'b0, 1'b0, 1'b1, 32'h0000_3002);
        step("mis_exc", 1'b0, 1'b0, 1'b1, 32'h0000_7000);
        step("oob_exc", 1'b0, 1'b0, 1'b0, 32'h0);
        step("to_end", 1'b0, 1'b0, 1'b1, IM_END);
        step("end_ok", 1'b0, 1'b0, 1'b1, 32'h0000_2FFC);
        step("below", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("top", 1'b0, 1'b0, 1'b0, 32'h0);
        step("wrap", 1'b0, 1'b0, 1'b1, 32'h0000_3020);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] tgt;
            tgt = R_PC + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt = tgt ^ 32'h0000_0002;
            step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0), tgt);
        end

        step("pre_rst", 1'b0, 1'b0, 1'b1, 32'h0000_3020);
        step("mid_rst", 1'b1, 1'b0, 1'b1, 32'h0000_3400);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_now("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b0, 32'h0);
        step("post_rst2", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IM_WORDS, default 4096, meaning the instruction memory depth in words, based at RESET_PC.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port stall, input, 1 bit: hazard stall from the decode stage; holds PC and IF/ID.
REQ-006 SHALL have port flush, input, 1 bit: clears IF/ID to a bubble.
REQ-007 SHALL have port redirect_valid, input, 1 bit: the decode stage supplies a taken branch/jump target.
REQ-008 SHALL have port redirect_pc, input, 32 bits: the target for redirect_valid.
REQ-009 SHALL have port im_addr, output, 32 bits: the current PC, fed to the combinational instruction ROM.
REQ-010 SHALL have port im_rdata, input, 32 bits: the ROM word at im_addr, valid in the same cycle.
REQ-011 SHALL have ports instr_d (32), pc_d (32), pc8_d (32), valid_d (1), exc_d (1), all outputs: IF/ID register contents.

Function
REQ-012 SHALL hold PC in a 32-bit register; im_addr = PC combinationally.
REQ-013 SHALL compute next PC without stall as redirect_pc if redirect_valid, else PC+4 (modulo 2^32; 0xFFFF_FFFC wraps to 0).
REQ-014 SHALL hold PC unchanged when stall=1, ignoring redirect_valid; decode re-presents the redirect next cycle.
REQ-015 SHALL mark fetch legal iff PC[1:0]==0 and RESET_PC <= PC <= RESET_PC+4*IM_WORDS-4.
REQ-016 SHALL, on legal fetch without stall/flush, load instr_d=im_rdata, pc_d=PC, pc8_d=PC+8, valid_d=1, exc_d=0.
REQ-017 SHALL, on illegal fetch, load instr_d=0 (nop), pc_d=PC, pc8_d=PC+8, valid_d=1, exc_d=1 (AdEL).
REQ-018 SHALL NOT flush the instruction after a branch (delay slot executes); redirect affects only PC.
REQ-019 SHALL, when flush=1, load IF/ID with instr_d=0, pc_d=0, pc8_d=0, valid_d=0, exc_d=0; flush overrides stall for IF/ID, while PC still obeys REQ-013/014.
REQ-020 SHALL hold IF/ID unchanged when stall=1 and flush=0.
REQ-021 SHALL have latency 1 cycle from im_addr to instr_d.

Reset
REQ-022 SHALL, on reset low (asynchronous), set PC=RESET_PC, instr_d=0, pc_d=0, pc8_d=0, valid_d=0, exc_d=0.
REQ-023 SHALL leave the first post-reset edge loading IF/ID from RESET_PC; a reset mid-stall or mid-redirect discards both.

Structure
REQ-024 SHALL take RESET_PC default, NOP encoding (32'h0) and AdEL code (4) from the shared CPU package.
REQ-025 SHALL contain one sub-module, pc_reg (PC register with stall/redirect mux); IF/ID logic is inline.

Verification
REQ-026 Release reset, no stall -> im_addr 0x3000, 0x3004, 0x3008 on successive edges; pc8_d=0x3008 when pc_d=0x3000.
REQ-027 redirect_valid=1, redirect_pc=0x3100 at PC=0x3008 -> next im_addr=0x3100; instr_d of 0x3008 (delay slot) still appears with valid_d=1.
REQ-028 stall=1 for 3 cycles with redirect_valid=1 -> PC and IF/ID frozen for those 3 cycles; redirect taken on the first cycle with stall=0.
REQ-029 stall=1 and flush=1 together at PC=0x3010 -> valid_d=0, instr_d=0; PC stays 0x3010.
REQ-030 redirect_pc=0x3002, then 0x7000 -> exc_d=1, instr_d=0 for each; PC continues 0x3006 and 0x7004 respectively.
REQ-031 Assert reset low asynchronously between edges at PC=0x3020 -> PC=0x3000 and valid_d=0 immediately, without waiting for a clock edge.
